// File: rtl/cnn1d_pkg.sv
// cnn1d_pkg: shared types and helpers for the 1-D CNN datapath blocks.
package cnn1d_pkg;
    typedef enum logic {GPOOL_AVG = 1'b0, GPOOL_MAX = 1'b1} gpool_mode_t;
    typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} gpool_state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/div.sv
// div: pipelined unsigned divide by a constant, PIPE_WIDTH clken-enabled stages of latency.
module div #(
    parameter int WIDTH      = 16,
    parameter int QWIDTH     = 16,
    parameter int DIVISOR    = 2,
    parameter int PIPE_WIDTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic [WIDTH-1:0]  dividend,
    output logic [QWIDTH-1:0] quotient
);
    logic [QWIDTH-1:0] pipe [PIPE_WIDTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_WIDTH; i++) pipe[i] <= '0;
        end else if (clken) begin
            pipe[0] <= QWIDTH'(dividend / WIDTH'(DIVISOR));
            for (int i = 1; i < PIPE_WIDTH; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign quotient = pipe[PIPE_WIDTH-1];
endmodule

// File: rtl/gpool_acc_bank.sv
// gpool_acc_bank: per-channel sum/max accumulators with per-channel clear and a channel read port.
module gpool_acc_bank
    import cnn1d_pkg::*;
#(
    parameter int ACC_WIDTH    = 20,
    parameter int NUM_CHANNELS = 4,
    parameter int CW           = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 wr_first,
    input  gpool_mode_t          wr_mode,
    input  logic [CW-1:0]        wr_chan,
    input  logic [ACC_WIDTH-1:0] wr_data,
    input  logic                 clr_en,
    input  logic [CW-1:0]        clr_chan,
    input  logic [CW-1:0]        rd_chan,
    output logic [ACC_WIDTH-1:0] rd_data
);
    logic [ACC_WIDTH-1:0] acc [NUM_CHANNELS];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++) acc[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (wr_en && wr_chan == CW'(c))
                    acc[c] <= wr_first ? wr_data :
                              (wr_mode == GPOOL_MAX) ? ((wr_data > acc[c]) ? wr_data : acc[c]) :
                              acc[c] + wr_data;
                else if (clr_en && clr_chan == CW'(c))
                    acc[c] <= '0;
            end
        end
    end
    assign rd_data = acc[rd_chan];
endmodule

// File: rtl/gpool_mc.sv
// gpool_mc: multi-channel global average/max pooling over a channel-interleaved ready/valid stream.
module gpool_mc
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH   = 12,
    parameter int NUM_CHANNELS = 4,
    parameter int POOL_SIZE    = 250,
    parameter int PIPE_WIDTH   = 4,
    localparam int CW          = idx_w(NUM_CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gpool_mode_in,
    output logic                  gpool_ready_in,
    input  logic                  gpool_valid_in,
    input  logic [DATA_WIDTH-1:0] gpool_data_in,
    input  logic                  gpool_ready_out,
    output logic                  gpool_valid_out,
    output logic [DATA_WIDTH-1:0] gpool_data_out,
    output logic [CW-1:0]         gpool_chan_out,
    output logic                  gpool_last_out
);
    localparam int SW = $clog2(POOL_SIZE);
    localparam int AW = DATA_WIDTH + SW;

    gpool_state_t state, state_nx;
    gpool_mode_t mode_q;
    logic [CW-1:0] chan_cnt, iss_cnt;
    logic [SW-1:0] samp_cnt;
    logic iss_done, beat, chan_wrap, samp_wrap, final_beat, stall_n, issue, iss_last, drain_done;
    logic [PIPE_WIDTH-1:0] vld_p, last_p, mode_p;
    logic [CW-1:0] chan_p [PIPE_WIDTH];
    logic [DATA_WIDTH-1:0] byp_p [PIPE_WIDTH];
    logic [AW-1:0] rd_data;
    logic [DATA_WIDTH-1:0] quot;

    assign gpool_ready_in = (state == ACCUM);
    assign beat       = gpool_valid_in & gpool_ready_in;
    assign chan_wrap  = (chan_cnt == CW'(NUM_CHANNELS - 1));
    assign samp_wrap  = (samp_cnt == SW'(POOL_SIZE - 1));
    assign final_beat = beat & chan_wrap & samp_wrap;
    assign stall_n    = ~gpool_valid_out | gpool_ready_out;
    assign issue      = (state == DRAIN) & ~iss_done & stall_n;
    assign iss_last   = (iss_cnt == CW'(NUM_CHANNELS - 1));
    // The pipe is empty once the only remaining valid entry is the one leaving this cycle.
    assign drain_done = iss_done & stall_n & ~|vld_p[PIPE_WIDTH-2:0];

    always_comb begin
        state_nx = (state == ACCUM) ? (final_beat ? DRAIN : ACCUM) : (drain_done ? ACCUM : DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACCUM;
            chan_cnt <= '0;
            samp_cnt <= '0;
            mode_q   <= GPOOL_AVG;
            iss_cnt  <= '0;
            iss_done <= 1'b0;
        end else begin
            state <= state_nx;
            if (beat) begin
                chan_cnt <= chan_wrap ? '0 : chan_cnt + 1'b1;
                if (chan_wrap) samp_cnt <= samp_wrap ? '0 : samp_cnt + 1'b1;
                if (samp_cnt == '0 && chan_cnt == '0) mode_q <= gpool_mode_t'(gpool_mode_in);
            end
            if (issue) begin
                iss_cnt  <= iss_last ? '0 : iss_cnt + 1'b1;
                iss_done <= iss_last;
            end else if (state == DRAIN && drain_done) begin
                iss_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            last_p <= '0;
            mode_p <= '0;
            for (int i = 0; i < PIPE_WIDTH; i++) begin
                chan_p[i] <= '0;
                byp_p[i]  <= '0;
            end
        end else if (stall_n) begin
            vld_p     <= {vld_p[PIPE_WIDTH-2:0], issue};
            last_p    <= {last_p[PIPE_WIDTH-2:0], issue & iss_last};
            mode_p    <= {mode_p[PIPE_WIDTH-2:0], mode_q == GPOOL_MAX};
            chan_p[0] <= iss_cnt;
            byp_p[0]  <= rd_data[DATA_WIDTH-1:0];
            for (int i = 1; i < PIPE_WIDTH; i++) begin
                chan_p[i] <= chan_p[i-1];
                byp_p[i]  <= byp_p[i-1];
            end
        end
    end

    gpool_acc_bank #(.ACC_WIDTH(AW), .NUM_CHANNELS(NUM_CHANNELS), .CW(CW)) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (beat),
        .wr_first (samp_cnt == '0),
        .wr_mode  (mode_q),
        .wr_chan  (chan_cnt),
        .wr_data  (AW'(gpool_data_in)),
        .clr_en   (issue),
        .clr_chan (iss_cnt),
        .rd_chan  (iss_cnt),
        .rd_data  (rd_data)
    );

    div #(.WIDTH(AW), .QWIDTH(DATA_WIDTH), .DIVISOR(POOL_SIZE), .PIPE_WIDTH(PIPE_WIDTH)) u_div (
        .clk      (clk),
        .rst      (rst),
        .clken    (stall_n),
        .dividend (rd_data),
        .quotient (quot)
    );

    assign gpool_valid_out = vld_p[PIPE_WIDTH-1];
    assign gpool_last_out  = last_p[PIPE_WIDTH-1];
    assign gpool_chan_out  = chan_p[PIPE_WIDTH-1];
    assign gpool_data_out  = mode_p[PIPE_WIDTH-1] ? byp_p[PIPE_WIDTH-1] : quot;
endmodule
